// File: rtl/friscv_cache_fetcher.sv
// Cache line refill engine: one aligned AXI4 INCR burst per miss, packed into a line buffer
// and written to the cache blocks in one full-strobe write. Optional macro: CACHE_FETCH_ERR_CHECK_EN.
module friscv_cache_fetcher #(
    parameter int ADDR_W        = 32,
    parameter int AXI_DATA_W    = 32,
    parameter int AXI_ID_W      = 8,
    parameter int AXI_ID        = 'h10,
    parameter int CACHE_BLOCK_W = 128
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       srst,
    input  logic                       miss_valid,
    output logic                       miss_ready,
    input  logic [ADDR_W-1:0]          miss_addr,
    output logic                       arvalid,
    input  logic                       arready,
    output logic [ADDR_W-1:0]          araddr,
    output logic [7:0]                 arlen,
    output logic [2:0]                 arsize,
    output logic [1:0]                 arburst,
    output logic [AXI_ID_W-1:0]        arid,
    input  logic                       rvalid,
    output logic                       rready,
    input  logic [AXI_DATA_W-1:0]      rdata,
    input  logic [1:0]                 rresp,
    input  logic                       rlast,
    output logic                       cache_wen,
    output logic [ADDR_W-1:0]          cache_waddr,
    output logic [CACHE_BLOCK_W-1:0]   cache_wdata,
    output logic [CACHE_BLOCK_W/8-1:0] cache_wstrb,
    output logic                       fetch_done,
    output logic                       fetch_err
);

    localparam int NB_BEATS = CACHE_BLOCK_W / AXI_DATA_W;
    localparam int CNT_W    = $clog2(NB_BEATS) + 1;
    localparam int OFF_W    = $clog2(CACHE_BLOCK_W / 8);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'((64'd1 << OFF_W) - 64'd1));

    // state | meaning
    // IDLE  | waiting for a miss, miss_ready high
    // ADDR  | AR request presented until arready
    // DATA  | collecting R beats into the line buffer
    // WRITE | single-cycle line write / completion pulse
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ADDR  = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] WRITE = 2'd3;

    logic [1:0]               state_q, state_d;
    logic                     ready_q, ready_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [CACHE_BLOCK_W-1:0] line_q, line_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     err_q, err_d;
    logic                     wr_cycle;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        line_d  = line_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (miss_valid && ready_q) begin
                    addr_d  = miss_addr & LINE_MASK;
                    line_d  = '0;
                    cnt_d   = '0;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (arready) state_d = DATA;
            end
            DATA: begin
                if (rvalid) begin
                    // a saturated counter matches no lane, so late beats are dropped
                    for (int i = 0; i < NB_BEATS; i++) begin
                        if (cnt_q == CNT_W'(i)) line_d[i*AXI_DATA_W +: AXI_DATA_W] = rdata;
                    end
                    if (cnt_q != CNT_W'(NB_BEATS)) cnt_d = cnt_q + CNT_W'(1);
`ifdef CACHE_FETCH_ERR_CHECK_EN
                    if ((rresp != 2'b00) || (rlast && (cnt_q != CNT_W'(NB_BEATS - 1))))
                        err_d = 1'b1;
`endif
                    if (rlast) state_d = WRITE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (srst) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
        if (state_d == IDLE) err_d = 1'b0;
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            addr_q  <= '0;
            line_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

`ifndef CACHE_FETCH_ERR_CHECK_EN
    logic unused_rresp;
    assign unused_rresp = ^rresp;
`endif

    assign wr_cycle    = (state_q == WRITE) && !srst;
    assign miss_ready  = ready_q;
    assign arvalid     = (state_q == ADDR) && !srst;
    assign araddr      = addr_q;
    assign arlen       = 8'(NB_BEATS - 1);
    assign arsize      = 3'($clog2(AXI_DATA_W / 8));
    assign arburst     = 2'b01;
    assign arid        = AXI_ID_W'(AXI_ID);
    assign rready      = (state_q == DATA) && !srst;
    assign cache_wen   = wr_cycle && !err_q;
    assign fetch_done  = wr_cycle && !err_q;
    assign fetch_err   = wr_cycle && err_q;
    assign cache_waddr = addr_q;
    assign cache_wdata = line_q;
    assign cache_wstrb = '1;

endmodule

// File: tb/tb_friscv_cache_fetcher.sv
// Scoreboard bench for friscv_cache_fetcher (default geometry: 4 beats of 32 bits per 128-bit line).
module tb_friscv_cache_fetcher;

    logic         aclk;
    logic         aresetn;
    logic         srst;
    logic         miss_valid;
    logic         miss_ready;
    logic [31:0]  miss_addr;
    logic         arvalid;
    logic         arready;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic [7:0]   arid;
    logic         rvalid;
    logic         rready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         cache_wen;
    logic [31:0]  cache_waddr;
    logic [127:0] cache_wdata;
    logic [15:0]  cache_wstrb;
    logic         fetch_done;
    logic         fetch_err;

    friscv_cache_fetcher dut (
        .aclk(aclk), .aresetn(aresetn), .srst(srst),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .arid(arid),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .cache_wen(cache_wen), .cache_waddr(cache_waddr), .cache_wdata(cache_wdata),
        .cache_wstrb(cache_wstrb), .fetch_done(fetch_done), .fetch_err(fetch_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0]  addr;
        logic [127:0] data;
        bit           err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int checks   = 0;
    int errors   = 0;
    int wen_seen = 0;
    int wen_exp  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #2;
    endtask

    // Monitor: every write/completion/error pulse must match the oldest expected refill
    initial begin
        forever begin
            @(negedge aclk);
            if (aresetn && (cache_wen || fetch_done || fetch_err)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: wen=%0b done=%0b err=%0b expected no pulse",
                             cache_wen, fetch_done, fetch_err);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("cache_wen", cache_wen, !mon_e.err);
                    chk("fetch_done", fetch_done, !mon_e.err);
                    chk("fetch_err", fetch_err, mon_e.err);
                    if (!mon_e.err) begin
                        wen_seen++;
                        chk("cache_waddr", cache_waddr, mon_e.addr);
                        chk("cache_wdata", cache_wdata, mon_e.data);
                        chk("cache_wstrb", cache_wstrb, 16'hFFFF);
                    end
                end
            end
        end
    end

    task automatic wait_accept(output bit ok);
        bit acc;
        acc = 1'b0;
        for (int t = 0; t < 50 && !acc; t++) begin
            acc = miss_ready;
            tick();
        end
        ok = acc;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: miss_ready stayed 0, expected 1 within 50 cycles");
        end
    endtask

    task automatic refill(input logic [31:0] addr, input int ar_wait, input bit gaps,
                          input int nbeats, input int bad_beat, input bit fixed,
                          input bit keep_valid, input logic [31:0] next_addr);
        logic [31:0]  beats [4];
        logic [127:0] line;
        logic [31:0]  la;
        exp_t         e;
        bit           err;
        bit           ok;
        la   = addr & ~32'hF;
        line = '0;
        err  = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            beats[i] = fixed ? 32'h11111111 * (i + 1) : $urandom;
            line[i*32 +: 32] = beats[i];
        end
`ifdef CACHE_FETCH_ERR_CHECK_EN
        err = (bad_beat >= 0 && bad_beat < nbeats) || (nbeats != 4);
`endif
        e.addr = la;
        e.data = line;
        e.err  = err;
        exp_q.push_back(e);
        if (!err) wen_exp++;

        miss_valid = 1'b1;
        miss_addr  = addr;
        wait_accept(ok);
        if (!ok) return;
        if (keep_valid) miss_addr = next_addr;
        else miss_valid = 1'b0;

        chk("arvalid_latency", arvalid, 1'b1);
        chk("araddr", araddr, la);
        chk("arlen", arlen, 8'd3);
        chk("arsize", arsize, 3'd2);
        chk("arburst", arburst, 2'b01);
        chk("arid", arid, 8'h10);
        for (int w = 0; w < ar_wait; w++) begin
            tick();
            chk("arvalid_hold", arvalid, 1'b1);
            chk("araddr_hold", araddr, la);
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk("rready", rready, 1'b1);
        chk("arvalid_drop", arvalid, 1'b0);
        for (int i = 0; i < nbeats; i++) begin
            if (gaps && ($urandom_range(1, 0) == 1)) begin
                rvalid = 1'b0;
                tick();
            end
            rvalid = 1'b1;
            rdata  = beats[i];
            rresp  = (i == bad_beat) ? 2'b10 : 2'b00;
            rlast  = (i == nbeats - 1);
            tick();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
        chk("miss_ready_in_write", miss_ready, 1'b0);
        tick();
        chk("miss_ready_after", miss_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        aresetn    = 1'b0;
        srst       = 1'b0;
        miss_valid = 1'b0;
        miss_addr  = '0;
        arready    = 1'b0;
        rvalid     = 1'b0;
        rdata      = '0;
        rresp      = 2'b00;
        rlast      = 1'b0;
        repeat (2) tick();
        chk("rst_miss_ready", miss_ready, 1'b0);
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_rready", rready, 1'b0);
        chk("rst_cache_wen", cache_wen, 1'b0);
        chk("rst_fetch_done", fetch_done, 1'b0);
        chk("rst_fetch_err", fetch_err, 1'b0);
        chk("rst_araddr", araddr, 32'h0);
        chk("rst_cache_waddr", cache_waddr, 32'h0);
        chk("rst_cache_wdata", cache_wdata, 128'h0);
        chk("rst_arlen", arlen, 8'd3);
        aresetn = 1'b1;
        tick();
        chk("post_rst_miss_ready", miss_ready, 1'b1);

        // basic refill, zero wait states
        refill(32'h1234, 0, 1'b0, 4, -1, 1'b1, 1'b0, 32'h0);
        // AR backpressure and rvalid gaps
        refill(32'h1234, 5, 1'b1, 4, -1, 1'b1, 1'b0, 32'h0);
        // back-to-back with miss_valid held high
        refill(32'h0, 0, 1'b0, 4, -1, 1'b0, 1'b1, 32'h40);
        refill(32'h40, 0, 1'b0, 4, -1, 1'b0, 1'b0, 32'h0);

        // synchronous reset in the middle of DATA
        miss_valid = 1'b1;
        miss_addr  = 32'h80;
        wait_accept(ok);
        miss_valid = 1'b0;
        if (ok) begin
            arready = 1'b1;
            tick();
            arready = 1'b0;
            for (int i = 0; i < 2; i++) begin
                rvalid = 1'b1;
                rdata  = $urandom;
                tick();
            end
            rvalid = 1'b0;
            srst   = 1'b1;
            tick();
            srst   = 1'b0;
            chk("srst_arvalid", arvalid, 1'b0);
            chk("srst_rready", rready, 1'b0);
            chk("srst_miss_ready", miss_ready, 1'b1);
            repeat (3) tick();
        end

        // bad response on beat 1, then short burst ending on beat 2 of 4
        refill(32'h2000, 0, 1'b0, 4, 1, 1'b0, 1'b0, 32'h0);
        refill(32'h3008, 1, 1'b0, 2, -1, 1'b0, 1'b0, 32'h0);

        for (int n = 0; n < 12; n++) begin
            int bad;
            bad = ($urandom_range(3, 0) == 0) ? int'($urandom_range(3, 0)) : -1;
            refill($urandom, int'($urandom_range(3, 0)), bit'($urandom_range(1, 0)), 4, bad,
                   1'b0, 1'b0, 32'h0);
        end

        repeat (5) tick();
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("wen_count", wen_seen, wen_exp);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
